// File: rtl/tt_um_ericsmi_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tt_um_ericsmi_uart_tx
//  Description : TinyTapeout 8N1 UART transmitter. A byte on ui_in is taken
//                when uio_in[0] strobes in IDLE with ena high. The byte is
//                then shifted out LSB first on uo_out[0]. uo_out also
//                carries busy, a one-cycle done pulse and a 5-bit wrapping
//                frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tt_um_ericsmi_uart_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST_CYC = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t          state_q;
    logic [7:0]      shift_q;
    logic [CW-1:0]   cyc_q;
    logic [2:0]      bit_q;
    logic            txd_q;
    logic            busy_q;
    logic            done_q;
    logic [4:0]      count_q;

    // Only the strobe bit of uio_in matters; the rest is deliberately dropped.
    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:1]};

    wire bit_end_w = (cyc_q == LAST_CYC);

    // Frame sequencer: every output is registered so txd changes only on edges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= 8'd0;
            cyc_q   <= '0;
            bit_q   <= 3'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= 5'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    // Accepting here also covers the done cycle, which lets
                    // the next start bit follow the stop bit directly.
                    if (ena && uio_in[0]) begin
                        shift_q <= ui_in;
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                        txd_q   <= 1'b0;
                        cyc_q   <= '0;
                        bit_q   <= 3'd0;
                    end
                end
                ST_START: begin
                    if (bit_end_w) begin
                        cyc_q   <= '0;
                        state_q <= ST_DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_w) begin
                        cyc_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            txd_q   <= shift_q[1];
                        end
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_w) begin
                        cyc_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        count_q <= count_q + 5'd1;
                    end else begin
                        cyc_q <= cyc_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign uo_out  = {count_q, done_q, busy_q, txd_q};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_ericsmi_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tt_um_ericsmi_uart_tx
//  Description : Scoreboard bench for the UART transmitter. Stimulus pushes
//                expected frames; a monitor decodes uo_out and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_ericsmi_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    tt_um_ericsmi_uart_tx #(.CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [4:0] cnt;
        logic       b2b;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] exp_cnt  = 5'd0;
    logic       mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one strobe and record the frame it must produce.
    task automatic send(input logic [7:0] b, input logic b2b);
        @(negedge clk);
        ui_in     = b;
        uio_in[0] = 1'b1;
        exp_cnt   = exp_cnt + 5'd1;
        sb_q.push_back('{data: b, cnt: exp_cnt, b2b: b2b});
        @(negedge clk);
        uio_in[0] = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (uo_out[2]) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: decodes every frame and compares against the scoreboard.
    initial begin
        int         gap;
        exp_t       e;
        logic [9:0] bits;
        gap = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                gap = 0;
                continue;
            end
            if (!uo_out[1]) begin
                if (uo_out[2]) chk("stray_done", 32'(uo_out[2]), 32'd0);
                if (!uo_out[0]) chk("idle_txd", 32'(uo_out[0]), 32'd1);
                gap++;
                continue;
            end
            if (sb_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
                e = '0;
            end else begin
                e = sb_q.pop_front();
            end
            if (e.b2b) chk("b2b_gap", 32'(gap), 32'd0);
            bits = '0;
            for (int i = 0; i < 40; i++) begin
                if (i > 0) @(negedge clk);
                chk("busy_in_frame", 32'(uo_out[1]), 32'd1);
                if (i % 4 == 0) bits[i/4] = uo_out[0];
                else chk("bit_hold", 32'(uo_out[0]), 32'(bits[i/4]));
            end
            @(negedge clk);
            chk("done_pulse", 32'(uo_out[2]), 32'd1);
            chk("busy_after", 32'(uo_out[1]), 32'd0);
            chk("txd_done_cycle", 32'(uo_out[0]), 32'd1);
            chk("frame_count", 32'(uo_out[7:3]), 32'(e.cnt));
            chk("start_bit", 32'(bits[0]), 32'd0);
            chk("stop_bit", 32'(bits[9]), 32'd1);
            chk("data_byte", 32'(bits[8:1]), 32'(e.data));
            gap = 0;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        bit clean;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset state and idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_uo_out", 32'(uo_out), 32'h01);
        end
        chk("uio_oe", 32'(uio_oe), 32'h00);
        chk("uio_out", 32'(uio_out), 32'h00);
        mon_en = 1'b1;

        // 2: single frame 0xA5
        send(8'hA5, 1'b0);
        wait_done();

        // 3: valid held -> back-to-back 0x00 then 0xFF; ui_in change mid-frame
        @(negedge clk);
        ui_in     = 8'h00;
        uio_in[0] = 1'b1;
        exp_cnt   = exp_cnt + 5'd1;
        sb_q.push_back('{data: 8'h00, cnt: exp_cnt, b2b: 1'b0});
        exp_cnt   = exp_cnt + 5'd1;
        sb_q.push_back('{data: 8'hFF, cnt: exp_cnt, b2b: 1'b1});
        @(negedge clk);
        ui_in = 8'hFF;
        wait_done();
        @(negedge clk);
        uio_in[0] = 1'b0;
        wait_done();
        repeat (5) @(negedge clk);

        // 4: strobes during a frame are ignored
        send(8'h3C, 1'b0);
        repeat (4) @(negedge clk);
        ui_in = 8'h55; uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (14) @(negedge clk);
        ui_in = 8'h66; uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        wait_done();
        repeat (50) @(negedge clk);

        // 5: ena low blocks accept; dropping ena mid-frame still completes
        ena = 1'b0;
        @(negedge clk);
        ui_in = 8'h81; uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (50) @(negedge clk);
        chk("ena_low_idle", 32'(uo_out[1:0]), 32'h1);
        ena = 1'b1;
        send(8'h96, 1'b0);
        repeat (10) @(negedge clk);
        ena = 1'b0;
        wait_done();
        ena = 1'b1;
        repeat (5) @(negedge clk);

        // 6: reset during DATA bit 3 aborts the frame
        mon_en = 1'b0;
        @(negedge clk);
        ui_in = 8'h5A; uio_in[0] = 1'b1;
        @(negedge clk);
        uio_in[0] = 1'b0;
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_uo_out", 32'(uo_out), 32'h01);
        clean = 1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uo_out !== 8'h01) clean = 0;
        end
        chk("abort_no_done", 32'(clean), 32'd1);
        exp_cnt = 5'd0;
        mon_en  = 1'b1;

        // 33 frames: counter wraps 31 -> 0 and ends at 1
        for (int f = 0; f < 33; f++) begin
            send(8'(f * 7 + 3), 1'b0);
            wait_done();
        end
        repeat (5) @(negedge clk);
        chk("wrap_count", 32'(uo_out[7:3]), 32'd1);
        chk("queue_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
